// File: rtl/count_event_pkg.sv
// rtl/count_event_pkg.sv - shared types and constants for the count event monitor
//
// Purpose: FSM state enum, event-code constants and the FIFO entry struct
// used by count_event_monitor and cem_event_fifo.
// Ports: none (package).

package count_event_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cem_state_e;

  localparam logic [1:0] WRAP = 2'b01;
  localparam logic [1:0] THR  = 2'b10;

  // Entry value field is sized for the widest supported sample; narrower
  // monitors zero-extend on push and truncate on the head.
  localparam int CEM_MAX_WIDTH = 32;

  typedef struct packed {
    logic [1:0]               code;
    logic [CEM_MAX_WIDTH-1:0] value;
  } cem_entry_t;

  function automatic logic [1:0] evt_code_of(input logic wrap, input logic thr);
    return (wrap ? WRAP : 2'b00) | (thr ? THR : 2'b00);
  endfunction

endpackage

// File: rtl/cem_event_fifo.sv
// rtl/cem_event_fifo.sv - synchronous first-word-fall-through event FIFO
//
// Purpose: buffers event entries between the detector and the consumer.
// The head is presented combinationally from storage whenever the FIFO
// is non-empty and reads as all zeros when empty.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous flush (wins over push/pop)
//   push        - write request, push_data is the entry
//   valid/ready - head valid / consumer accepts head
//   head        - current head entry
//   overflow    - push was rejected because the FIFO was full with no pop

module cem_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  T     push_data,
  output logic valid,
  input  logic ready,
  output T     head,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           do_pop;
  logic           do_push;

  assign valid    = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = valid && ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - counter wrap / threshold-crossing event monitor
//
// Purpose: watches successive samples of an upstream counter and queues an
// event when the counter wraps (new < previous) or rises across THRESH.
// Optional build macro: CEM_DROP_CNT_EN enables the saturating drop counter;
// without it drop_cnt reads 0 and overflowing events are silently dropped.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   clr             - synchronous soft clear (flush, IDLE, drop_cnt=0)
//   in_valid        - in_count holds a new sample
//   in_count        - upstream counter value
//   evt_valid/ready - event FIFO head handshake
//   evt_code        - 01 wrap, 10 threshold, 11 both
//   evt_value       - sample that raised the head event
//   status_bit      - MSB of last accepted sample
//   partial_data    - low nibble of last accepted sample
//   drop_cnt        - events lost to a full FIFO

module count_event_monitor
  import count_event_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] THRESH = 8'h80,
  parameter int               DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             status_bit,
  output logic [3:0]       partial_data,
  output logic [7:0]       drop_cnt
);

  cem_state_e       state;
  logic [WIDTH-1:0] prev;
  logic             sample;
  logic             wrap;
  logic             thr;
  logic             push;
  logic             overflow;
  cem_entry_t       push_entry;
  cem_entry_t       head;

  // A sample arriving together with clr is discarded.
  assign sample = in_valid && !clr;
  assign wrap   = (in_count < prev);
  assign thr    = (prev < THRESH) && (in_count >= THRESH);
  assign push   = sample && (state == ARMED) && (wrap || thr);

  always_comb begin
    push_entry       = '0;
    push_entry.code  = evt_code_of(wrap, thr);
    push_entry.value = CEM_MAX_WIDTH'(in_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev         <= '0;
      status_bit   <= 1'b0;
      partial_data <= 4'h0;
    end else if (clr) begin
      state <= IDLE;
    end else if (in_valid) begin
      state        <= ARMED;
      prev         <= in_count;
      status_bit   <= in_count[WIDTH-1];
      partial_data <= in_count[3:0];
    end
  end

  cem_event_fifo #(
    .DEPTH (DEPTH),
    .T     (cem_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .push_data (push_entry),
    .valid     (evt_valid),
    .ready     (evt_ready),
    .head      (head),
    .overflow  (overflow)
  );

  assign evt_code  = head.code;
  assign evt_value = head.value[WIDTH-1:0];

  generate
    if (WIDTH < CEM_MAX_WIDTH) begin : g_value_pad
      logic unused_value_bits;
      assign unused_value_bits = ^head.value[CEM_MAX_WIDTH-1:WIDTH];
    end
  endgenerate

`ifdef CEM_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'h00;
    end else if (clr) begin
      drop_cnt <= 8'h00;
    end else if (overflow && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign drop_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - self-checking bench for count_event_monitor

module tb_count_event_monitor;

`ifdef CEM_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_count;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [7:0] evt_value;
  logic       status_bit;
  logic [3:0] partial_data;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  count_event_monitor #(
    .WIDTH  (8),
    .THRESH (8'h80),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_count     (in_count),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_value    (evt_value),
    .status_bit   (status_bit),
    .partial_data (partial_data),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic       iv;
    logic [7:0] cnt;
    logic       rdy;
    logic       ev;
    logic [1:0] code;
    logic [7:0] val;
    logic       st;
    logic [3:0] pd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic iv, input logic [7:0] cnt, input logic rdy);
    clr       = c;
    in_valid  = iv;
    in_count  = cnt;
    evt_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ovf_exp [4];
  logic [7:0] bp_cnt  [4];
  logic [1:0] bp_code [4];

  initial begin
    // Each row: inputs held for one clock, outputs checked just after it.
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 2'd1, 8'h05, 1'b0, 4'h5};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5};
    vecs[3]  = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF};
    vecs[4]  = '{1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 2'd2, 8'h80, 1'b1, 4'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h90, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 4'h0};
    vecs[6]  = '{1'b0, 1'b1, 8'h70, 1'b0, 1'b1, 2'd1, 8'h70, 1'b0, 4'h0};
    vecs[7]  = '{1'b0, 1'b1, 8'h60, 1'b1, 1'b1, 2'd1, 8'h60, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 2'd2, 8'hF0, 1'b1, 4'h0};
    vecs[9]  = '{1'b0, 1'b1, 8'h85, 1'b1, 1'b1, 2'd1, 8'h85, 1'b1, 4'h5};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 4'h5};
    vecs[11] = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 2'd1, 8'h20, 1'b0, 4'h0};
    vecs[12] = '{1'b1, 1'b1, 8'h9A, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h5};
    vecs[14] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 2'd1, 8'h03, 1'b0, 4'h3};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'h3};

    ovf_exp = '{8'h30, 8'h20, 8'h10, 8'h02};
    bp_cnt  = '{8'h90, 8'h10, 8'h05, 8'h84};
    bp_code = '{2'd2, 2'd1, 2'd1, 2'd2};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    chk("reset.valid",   {31'd0, evt_valid},    32'd0);
    chk("reset.code",    {30'd0, evt_code},     32'd0);
    chk("reset.value",   {24'd0, evt_value},    32'd0);
    chk("reset.status",  {31'd0, status_bit},   32'd0);
    chk("reset.partial", {28'd0, partial_data}, 32'd0);
    chk("reset.drop",    {24'd0, drop_cnt},     32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].c, vecs[i].iv, vecs[i].cnt, vecs[i].rdy);
      tick();
      chk($sformatf("row%0d.valid", i),   {31'd0, evt_valid},    {31'd0, vecs[i].ev});
      chk($sformatf("row%0d.code", i),    {30'd0, evt_code},     {30'd0, vecs[i].code});
      chk($sformatf("row%0d.value", i),   {24'd0, evt_value},    {24'd0, vecs[i].val});
      chk($sformatf("row%0d.status", i),  {31'd0, status_bit},   {31'd0, vecs[i].st});
      chk($sformatf("row%0d.partial", i), {28'd0, partial_data}, {28'd0, vecs[i].pd});
      chk($sformatf("row%0d.drop", i),    {24'd0, drop_cnt},     32'd0);
    end

    // Overflow: six wraps into a four-deep FIFO with the consumer stalled.
    drive(1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h50, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h40, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h30, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h20, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h10, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h08, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h04, 1'b0); tick();
    chk("ovf.valid", {31'd0, evt_valid}, 32'd1);
    chk("ovf.head",  {24'd0, evt_value}, 32'h40);
    chk("ovf.drop",  {24'd0, drop_cnt},  DROP_EN ? 32'd2 : 32'd0);
    // Push plus pop on a full FIFO is accepted without counting a drop.
    drive(1'b0, 1'b1, 8'h02, 1'b1); tick();
    chk("ovf.pushpop.drop", {24'd0, drop_cnt}, DROP_EN ? 32'd2 : 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf.drain%0d.valid", k), {31'd0, evt_valid}, 32'd1);
      chk($sformatf("ovf.drain%0d.value", k), {24'd0, evt_value}, {24'd0, ovf_exp[k]});
      chk($sformatf("ovf.drain%0d.code", k),  {30'd0, evt_code},  32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1); tick();
    end
    chk("ovf.empty", {31'd0, evt_valid}, 32'd0);

    // Clear mid-stream with three events queued and a sample in the same cycle.
    drive(1'b0, 1'b1, 8'h01, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h00, 1'b0); tick();
    drive(1'b0, 1'b1, 8'hFF, 1'b0); tick();
    chk("clr.pre.valid", {31'd0, evt_valid}, 32'd1);
    chk("clr.pre.head",  {24'd0, evt_value}, 32'h01);
    drive(1'b1, 1'b1, 8'h7A, 1'b0); tick();
    chk("clr.valid",   {31'd0, evt_valid},    32'd0);
    chk("clr.drop",    {24'd0, drop_cnt},     32'd0);
    chk("clr.status",  {31'd0, status_bit},   32'd1);
    chk("clr.partial", {28'd0, partial_data}, 32'hF);
    drive(1'b0, 1'b1, 8'h01, 1'b0); tick();
    chk("clr.rearm.valid",   {31'd0, evt_valid},    32'd0);
    chk("clr.rearm.partial", {28'd0, partial_data}, 32'h1);

    // Backpressure: random ready, in-order delivery, stable head while stalled.
    begin
      int         got = 0;
      logic       stalled = 1'b0;
      logic [1:0] held_code = 2'd0;
      logic [7:0] held_val = 8'h00;
      logic       rdy;
      for (int c = 0; c < 60; c++) begin
        rdy = (c >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
        if (c < 4) drive(1'b0, 1'b1, bp_cnt[c], rdy);
        else       drive(1'b0, 1'b0, 8'h00, rdy);
        if (stalled) begin
          chk($sformatf("bp.c%0d.stable_code", c),  {30'd0, evt_code},  {30'd0, held_code});
          chk($sformatf("bp.c%0d.stable_value", c), {24'd0, evt_value}, {24'd0, held_val});
        end
        if (evt_valid && rdy) begin
          if (got < 4) begin
            chk($sformatf("bp.ev%0d.code", got),  {30'd0, evt_code},  {30'd0, bp_code[got]});
            chk($sformatf("bp.ev%0d.value", got), {24'd0, evt_value}, {24'd0, bp_cnt[got]});
          end else begin
            chk("bp.extra_event", 32'd1, 32'd0);
          end
          got++;
        end
        stalled   = evt_valid && !rdy;
        held_code = evt_code;
        held_val  = evt_value;
        tick();
      end
      chk("bp.delivered", got, 32'd4);
    end

    // Asynchronous reset in the middle of operation.
    drive(1'b0, 1'b1, 8'h10, 1'b0); tick();
    chk("rst.pre.valid", {31'd0, evt_valid}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst.async.valid",  {31'd0, evt_valid},  32'd0);
    chk("rst.async.value",  {24'd0, evt_value},  32'd0);
    chk("rst.async.status", {31'd0, status_bit}, 32'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h05, 1'b0); tick();
    chk("rst.first.valid", {31'd0, evt_valid}, 32'd0);
    drive(1'b0, 1'b1, 8'h03, 1'b0); tick();
    chk("rst.rearm.valid", {31'd0, evt_valid}, 32'd1);
    chk("rst.rearm.value", {24'd0, evt_value}, 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
